// File: rtl/frame_buffer_ctrl.sv
// frame_buffer_ctrl: frame-buffer controller between the UART pixel receiver
// and the display scanner. Receive mode streams W*H pixels into a single-port
// SRAM at sequential addresses; display mode maps (x,y) to y*W+x through a
// three-cycle read pipeline and returns BG_COLOR outside the image.
// Optional build macro: FB_SCALE_EN (coordinates shifted right by SCALE_SH).
//
// FSM states
//   state  | meaning
//   IDLE   | no frame activity, counters and flags cleared
//   RECV   | frame reception in progress, one SRAM write per rx_valid
//   DONE   | full frame stored, further rx_valid flagged as overflow
//   DISP   | display reads, pipelined one coordinate per cycle
module frame_buffer_ctrl #(
  parameter int               W        = 50,
  parameter int               H        = 40,
  parameter int               PIX_W    = 12,
  parameter int               ADDR_W   = 15,
  parameter logic [PIX_W-1:0] BG_COLOR = '0,
  parameter int               SCALE_SH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        state,
  input  logic              rx_valid,
  input  logic [PIX_W-1:0]  rx_data,
  input  logic [9:0]        x_addr,
  input  logic [9:0]        y_addr,
  output logic [PIX_W-1:0]  pixel_data,
  output logic              pixel_valid,
  output logic              image_receiving,
  output logic              image_complete,
  output logic              rx_overflow,
  output logic [ADDR_W-1:0] spram_addr,
  output logic [PIX_W-1:0]  spram_wr_data,
  output logic              spram_wre,
  input  logic [PIX_W-1:0]  spram_rd_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2,
    S_DISP = 2'd3
  } fsm_t;

  localparam int              NPIX = W * H;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(NPIX - 1);
  localparam logic [15:0]     W16  = 16'(W);
  localparam logic [15:0]     H16  = 16'(H);

  fsm_t              fsm;
  fsm_t              fsm_nxt;
  logic [ADDR_W:0]   pix_cnt;
  logic              mode_idle;
  logic              mode_recv;
  logic              mode_disp;
  logic              wr_en;
  logic              last_wr;
  logic              disp_run;
  logic [9:0]        xs;
  logic [9:0]        ys;
  logic              in_rng;
  logic [ADDR_W-1:0] rd_addr;
  logic              in_d1;
  logic              in_d2;

  assign mode_idle = (state == 8'h01);
  assign mode_recv = (state == 8'h02);
  assign mode_disp = (state == 8'h03);

  // pix_cnt stays at or below LAST while receiving, so the guard also stops any wrap
  assign wr_en    = (fsm == S_RECV) && rx_valid && mode_recv && (pix_cnt <= LAST);
  assign last_wr  = wr_en && (pix_cnt == LAST);

  // the pipeline runs only while DISP is held; an exit clears it on the same edge
  assign disp_run = (fsm == S_DISP) && !mode_idle;

`ifdef FB_SCALE_EN
  assign xs = x_addr >> SCALE_SH;
  assign ys = y_addr >> SCALE_SH;
`else
  assign xs = x_addr;
  assign ys = y_addr;
`endif

  assign in_rng  = ({6'd0, xs} < W16) && ({6'd0, ys} < H16);
  assign rd_addr = ADDR_W'(ys) * ADDR_W'(W) + ADDR_W'(xs);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= S_IDLE;
    else     fsm <= fsm_nxt;
  end

  // next-state decode from the top-level mode byte
  always_comb begin
    fsm_nxt = fsm;
    if (mode_idle) begin
      fsm_nxt = S_IDLE;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (mode_recv)      fsm_nxt = S_RECV;
          else if (mode_disp) fsm_nxt = S_DISP;
        end
        S_RECV: begin
          if (mode_disp)    fsm_nxt = S_DISP;
          else if (last_wr) fsm_nxt = S_DONE;
        end
        S_DONE: begin
          if (mode_disp) fsm_nxt = S_DISP;
        end
        default: fsm_nxt = fsm;
      endcase
    end
  end

  // pixel counter and frame status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt         <= '0;
      image_receiving <= 1'b0;
      image_complete  <= 1'b0;
      rx_overflow     <= 1'b0;
    end else if (mode_idle) begin
      pix_cnt         <= '0;
      image_receiving <= 1'b0;
      image_complete  <= 1'b0;
      rx_overflow     <= 1'b0;
    end else begin
      if (fsm == S_IDLE && mode_recv) begin
        pix_cnt         <= '0;
        image_receiving <= 1'b1;
      end
      if (wr_en) begin
        pix_cnt <= pix_cnt + 1'b1;
        if (last_wr) begin
          image_complete  <= 1'b1;
          image_receiving <= 1'b0;
        end
      end
      if (fsm == S_RECV && mode_disp) image_receiving <= 1'b0;
      if (mode_recv && rx_valid && fsm != S_RECV) rx_overflow <= 1'b1;
    end
  end

  // SRAM port: write address/data on receive, read address while displaying
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spram_addr    <= '0;
      spram_wr_data <= '0;
      spram_wre     <= 1'b0;
    end else begin
      spram_wre <= wr_en;
      if (wr_en) begin
        spram_addr    <= pix_cnt[ADDR_W-1:0];
        spram_wr_data <= rx_data;
      end else if (disp_run) begin
        spram_addr <= rd_addr;
      end
    end
  end

  // range flag follows the read through the SRAM latency, then selects the pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_d1       <= 1'b0;
      in_d2       <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_data  <= BG_COLOR;
    end else begin
      in_d1       <= disp_run && in_rng;
      in_d2       <= disp_run && in_d1;
      pixel_valid <= disp_run && in_d2;
      pixel_data  <= (disp_run && in_d2) ? spram_rd_data : BG_COLOR;
    end
  end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Scoreboard bench for frame_buffer_ctrl with a behavioural synchronous SRAM.
module tb_frame_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  state;
  logic        rx_valid;
  logic [11:0] rx_data;
  logic [9:0]  x_addr;
  logic [9:0]  y_addr;
  logic [11:0] pixel_data;
  logic        pixel_valid;
  logic        image_receiving;
  logic        image_complete;
  logic        rx_overflow;
  logic [14:0] spram_addr;
  logic [11:0] spram_wr_data;
  logic        spram_wre;
  logic [11:0] spram_rd_data;

  logic [11:0] mem [0:32767];

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       nm;
  } chk_t;

  typedef struct {
    logic [14:0] a;
    logic [11:0] d;
  } wr_t;

  chk_t sq[$];
  wr_t  wq[$];
  int   cyc = 0;
  int   wr_total = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   base;

  localparam int SEL_ADDR = 0, SEL_PIX = 1, SEL_VLD = 2, SEL_RECV = 3;
  localparam int SEL_CMPL = 4, SEL_OVF = 5, SEL_WRE = 6, SEL_WRCNT = 7, SEL_WQ = 8;

  frame_buffer_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .state           (state),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .x_addr          (x_addr),
    .y_addr          (y_addr),
    .pixel_data      (pixel_data),
    .pixel_valid     (pixel_valid),
    .image_receiving (image_receiving),
    .image_complete  (image_complete),
    .rx_overflow     (rx_overflow),
    .spram_addr      (spram_addr),
    .spram_wr_data   (spram_wr_data),
    .spram_wre       (spram_wre),
    .spram_rd_data   (spram_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read single-port SRAM
  always @(posedge clk) begin
    if (spram_wre) mem[spram_addr] <= spram_wr_data;
    spram_rd_data <= mem[spram_addr];
  end

  function automatic logic [31:0] sample(int sel);
    case (sel)
      SEL_ADDR:  return 32'(spram_addr);
      SEL_PIX:   return 32'(pixel_data);
      SEL_VLD:   return 32'(pixel_valid);
      SEL_RECV:  return 32'(image_receiving);
      SEL_CMPL:  return 32'(image_complete);
      SEL_OVF:   return 32'(rx_overflow);
      SEL_WRE:   return 32'(spram_wre);
      SEL_WRCNT: return 32'(wr_total);
      SEL_WQ:    return 32'(wq.size());
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask

  // monitor: pops writes as the DUT strobes spram_wre, and timed checks when due
  always @(negedge clk) begin
    if (spram_wre === 1'b1) begin
      wr_total++;
      if (wq.size() == 0) begin
        cmp("unexpected_write_addr", 32'(spram_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = wq.pop_front();
        cmp("wr_addr", 32'(spram_addr), 32'(w.a));
        cmp("wr_data", 32'(spram_wr_data), 32'(w.d));
        cmp("wr_complete", 32'(image_complete), (w.a == 15'd1999) ? 32'd1 : 32'd0);
        cmp("wr_receiving", 32'(image_receiving), (w.a == 15'd1999) ? 32'd0 : 32'd1);
      end
    end
    for (int i = sq.size() - 1; i >= 0; i--) begin
      if (sq[i].due < cyc) begin
        cmp({sq[i].nm, "_missed"}, 32'(sq[i].due), 32'(cyc));
        sq.delete(i);
      end else if (sq[i].due == cyc) begin
        cmp(sq[i].nm, sample(sq[i].sel), sq[i].exp);
        sq.delete(i);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(int d, int sel, logic [31:0] exp, string nm);
    chk_t c;
    c.due = cyc + d;
    c.sel = sel;
    c.exp = exp;
    c.nm  = nm;
    sq.push_back(c);
  endtask

  task automatic send_px(logic [14:0] a, logic [11:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    wq.push_back(w);
    rx_valid = 1'b1;
    rx_data  = d;
    tick(1);
  endtask

  task automatic rd(logic [9:0] x, logic [9:0] y, logic [14:0] a, logic [11:0] pix, logic vld,
                    string nm);
    x_addr = x;
    y_addr = y;
    expect_at(1, SEL_ADDR, 32'(a), {nm, "_addr"});
    expect_at(3, SEL_PIX, 32'(pix), {nm, "_pix"});
    expect_at(3, SEL_VLD, 32'(vld), {nm, "_valid"});
    tick(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    state    = 8'h00;
    rx_valid = 1'b0;
    rx_data  = 12'h000;
    x_addr   = 10'd0;
    y_addr   = 10'd0;
    tick(3);
    expect_at(0, SEL_ADDR, 0, "rst_addr");
    expect_at(0, SEL_PIX,  0, "rst_pix");
    expect_at(0, SEL_VLD,  0, "rst_valid");
    expect_at(0, SEL_RECV, 0, "rst_recv");
    expect_at(0, SEL_CMPL, 0, "rst_complete");
    expect_at(0, SEL_OVF,  0, "rst_ovf");
    expect_at(0, SEL_WRE,  0, "rst_wre");
    rst = 1'b0;
    tick(1);

    // aborted frame: 10 pixels with gaps, then reset mid-frame
    state = 8'h01; tick(1);
    state = 8'h02; tick(1);
    expect_at(0, SEL_RECV, 1, "recv_entry");
    for (int i = 0; i < 10; i++) begin
      send_px(15'(i), 12'hA00 + 12'(i));
      rx_valid = 1'b0;
      tick(1);
    end
    tick(2);
    rst = 1'b1;
    expect_at(0, SEL_RECV, 0, "midrst_recv");
    expect_at(0, SEL_CMPL, 0, "midrst_complete");
    expect_at(0, SEL_WRE,  0, "midrst_wre");
    expect_at(0, SEL_PIX,  0, "midrst_pix");
    expect_at(0, SEL_ADDR, 0, "midrst_addr");
    tick(2);
    rst = 1'b0;
    tick(1);

    // full frame, back-to-back, data = address
    state = 8'h01; tick(1);
    state = 8'h02; tick(1);
    base = wr_total;
    for (int i = 0; i < 2000; i++) send_px(15'(i), 12'(i));
    rx_valid = 1'b0;
    expect_at(1, SEL_WRCNT, 32'(base + 2000), "frame_write_count");
    expect_at(1, SEL_CMPL, 1, "frame_complete");
    expect_at(1, SEL_RECV, 0, "frame_recv_low");
    tick(2);

    // overflow after completion, hold mode, then clear through idle
    rx_valid = 1'b1; rx_data = 12'hBAD;
    tick(1);
    rx_valid = 1'b0;
    expect_at(0, SEL_OVF, 1, "overflow_set");
    expect_at(0, SEL_CMPL, 1, "overflow_complete_kept");
    state = 8'h00; tick(2);
    expect_at(0, SEL_OVF, 1, "hold_ovf");
    expect_at(0, SEL_CMPL, 1, "hold_complete");
    state = 8'h01; tick(1);
    expect_at(0, SEL_OVF, 0, "idle_ovf_clear");
    expect_at(0, SEL_CMPL, 0, "idle_complete_clear");
    expect_at(0, SEL_RECV, 0, "idle_recv_clear");

    // display reads
    state = 8'h03; tick(2);
`ifndef FB_SCALE_EN
    rd(10'd3,  10'd2,  15'd103,  12'h067, 1'b1, "rd_3_2");
    rd(10'd50, 10'd0,  15'd50,   12'h000, 1'b0, "rd_50_0");
    rd(10'd0,  10'd0,  15'd0,    12'h000, 1'b1, "rd_0_0");
    rd(10'd49, 10'd39, 15'd1999, 12'h7CF, 1'b1, "rd_49_39");
    rd(10'd0,  10'd40, 15'd2000, 12'h000, 1'b0, "rd_0_40");
    rd(10'd10, 10'd1,  15'd60,   12'h03C, 1'b1, "rd_10_1");
`endif
    tick(4);

    // leave and re-enter display: background for three cycles after re-entry
    x_addr = 10'd3; y_addr = 10'd2;
    state = 8'h01; tick(1);
    expect_at(0, SEL_VLD, 0, "exit_valid");
    expect_at(0, SEL_PIX, 0, "exit_pix");
    tick(1);
    state = 8'h03;
    for (int d = 1; d <= 3; d++) begin
      expect_at(d, SEL_VLD, 0, "reentry_bg_valid");
      expect_at(d, SEL_PIX, 0, "reentry_bg_pix");
    end
    expect_at(4, SEL_VLD, 1, "reentry_valid");
`ifdef FB_SCALE_EN
    expect_at(4, SEL_PIX, 32'h033, "reentry_pix");
`else
    expect_at(4, SEL_PIX, 32'h067, "reentry_pix");
`endif
    tick(6);

    // partial frame abandoned by switching to display
    state = 8'h01; tick(1);
    state = 8'h02; tick(1);
    for (int i = 0; i < 500; i++) send_px(15'(i), 12'(i) ^ 12'hFFF);
    rx_valid = 1'b0;
    state = 8'h03;
    tick(1);
    expect_at(0, SEL_CMPL, 0, "partial_complete");
    expect_at(0, SEL_RECV, 0, "partial_recv");
`ifdef FB_SCALE_EN
    rd(10'd7,   10'd5,  15'd103,  12'hF98, 1'b1, "scale_7_5");
    rd(10'd99,  10'd79, 15'd1999, 12'h7CF, 1'b1, "scale_99_79");
    rd(10'd100, 10'd0,  15'd50,   12'h000, 1'b0, "scale_100_0");
`else
    rd(10'd3,  10'd2,  15'd103, 12'hF98, 1'b1, "partial_3_2");
    rd(10'd49, 10'd9,  15'd499, 12'hE0C, 1'b1, "partial_49_9");
    rd(10'd0,  10'd10, 15'd500, 12'h1F4, 1'b1, "partial_0_10");
`endif
    tick(6);
    expect_at(0, SEL_WQ, 0, "pending_writes");
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
